// File: rtl/derrida_distance_histogram.sv
// Derrida distance histogram: bins 2-bit Hamming distances over fixed windows of
// WINDOW samples and serially emits the four bin counts plus the window sum.
// A shadow bank holds the closed window so accumulation never stalls.
module derrida_distance_histogram #(
  parameter int WINDOW      = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  input  logic [1:0]             input_data,
  output logic                   output_valid,
  output logic [1:0]             output_bin,
  output logic [COUNT_WIDTH-1:0] output_count,
  output logic [COUNT_WIDTH+1:0] output_sum,
  output logic                   output_last,
  output logic [15:0]            window_count
);

  typedef enum logic {
    S_IDLE,
    S_DUMP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic                   emit;
  logic                   close;

  logic [COUNT_WIDTH-1:0] live_bin_q [4];
  logic [COUNT_WIDTH-1:0] live_bin_d [4];
  logic [COUNT_WIDTH+1:0] live_sum_q, live_sum_d;
  logic [COUNT_WIDTH-1:0] sample_cnt_q;

  logic [COUNT_WIDTH-1:0] shd_bin_q [4];
  logic [COUNT_WIDTH+1:0] shd_sum_q;

  logic [15:0]            window_count_q;

  assign window_count = window_count_q;

  // Live bank values including the current sample; these feed the shadow at close.
  always_comb begin
    close = input_valid && (sample_cnt_q == COUNT_WIDTH'(WINDOW - 1));
    for (int k = 0; k < 4; k++) begin
      live_bin_d[k] = live_bin_q[k];
      if (input_valid && (input_data == 2'(k))) begin
        live_bin_d[k] = live_bin_q[k] + COUNT_WIDTH'(1);
      end
    end
    live_sum_d = live_sum_q;
    if (input_valid) begin
      live_sum_d = live_sum_q + {{COUNT_WIDTH{1'b0}}, input_data};
    end
  end

  // Live accumulation; a closing sample clears the bank rather than seeding it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) live_bin_q[k] <= '0;
      live_sum_q   <= '0;
      sample_cnt_q <= '0;
    end else if (close) begin
      for (int k = 0; k < 4; k++) live_bin_q[k] <= '0;
      live_sum_q   <= '0;
      sample_cnt_q <= '0;
    end else if (input_valid) begin
      for (int k = 0; k < 4; k++) live_bin_q[k] <= live_bin_d[k];
      live_sum_q   <= live_sum_d;
      sample_cnt_q <= sample_cnt_q + COUNT_WIDTH'(1);
    end
  end

  // Shadow bank and window counter capture the finished window at close.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) shd_bin_q[k] <= '0;
      shd_sum_q      <= '0;
      window_count_q <= '0;
    end else if (close) begin
      for (int k = 0; k < 4; k++) shd_bin_q[k] <= live_bin_d[k];
      shd_sum_q      <= live_sum_d;
      window_count_q <= window_count_q + 16'd1;
    end
  end

  // Emitter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Emitter next state: walk bins 0..3, chaining straight into a new dump when
  // the next window closes on the bin-3 cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    emit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (close) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        emit = 1'b1;
        if (idx_q == 2'd3) begin
          idx_d = '0;
          if (!close) state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output register: bin 3 is read from the shadow before a same-edge reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_valid <= 1'b0;
      output_last  <= 1'b0;
      output_bin   <= '0;
      output_count <= '0;
      output_sum   <= '0;
    end else begin
      output_valid <= emit;
      output_last  <= emit && (idx_q == 2'd3);
      if (emit) begin
        output_bin   <= idx_q;
        output_count <= shd_bin_q[idx_q];
        output_sum   <= shd_sum_q;
      end
    end
  end

endmodule

// File: tb/tb_derrida_distance_histogram.sv
// Bench for derrida_distance_histogram: three instances (WINDOW 4, 8, 64) against
// a per-instance behavioural model that schedules expected dump cycles.
module tb_derrida_distance_histogram;

  localparam int N = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a [3];
  logic        vld   [3];
  logic [1:0]  dat   [3];
  logic        ov    [3];
  logic [1:0]  ob    [3];
  logic [15:0] oc    [3];
  logic [17:0] os    [3];
  logic        ol    [3];
  logic [15:0] wc    [3];

  derrida_distance_histogram #(.WINDOW(4), .COUNT_WIDTH(16)) u_w4 (
    .clk(clk), .rst(rst_a[0]), .input_valid(vld[0]), .input_data(dat[0]),
    .output_valid(ov[0]), .output_bin(ob[0]), .output_count(oc[0]),
    .output_sum(os[0]), .output_last(ol[0]), .window_count(wc[0]));

  derrida_distance_histogram #(.WINDOW(8), .COUNT_WIDTH(16)) u_w8 (
    .clk(clk), .rst(rst_a[1]), .input_valid(vld[1]), .input_data(dat[1]),
    .output_valid(ov[1]), .output_bin(ob[1]), .output_count(oc[1]),
    .output_sum(os[1]), .output_last(ol[1]), .window_count(wc[1]));

  derrida_distance_histogram #(.WINDOW(64), .COUNT_WIDTH(16)) u_w64 (
    .clk(clk), .rst(rst_a[2]), .input_valid(vld[2]), .input_data(dat[2]),
    .output_valid(ov[2]), .output_bin(ob[2]), .output_count(oc[2]),
    .output_sum(os[2]), .output_last(ol[2]), .window_count(wc[2]));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d: got %0d, expected %0d", nm, inst, cyc, act, exp);
    end
  endtask

  // Behavioural model: window contents, and per-cycle expected outputs.
  int wsz [3] = '{4, 8, 64};
  int mbin [3][4];
  int msum [3];
  int mcnt [3];
  int mwc  [3];
  bit ev [3][N];
  int eb [3][N];
  int ec [3][N];
  int es [3][N];
  bit el [3][N];
  bit ez [3][N];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc + 6 >= N) begin
      $display("FAIL watchdog cyc=%0d: got no finish, expected finish", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    for (int i = 0; i < 3; i++) begin
      if (rst_a[i]) begin
        for (int b = 0; b < 4; b++) mbin[i][b] = 0;
        msum[i] = 0;
        mcnt[i] = 0;
        mwc[i]  = 0;
        for (int k = 0; k <= 4; k++) ev[i][cyc+k] = 1'b0;
        ez[i][cyc] = 1'b1;
      end else if (vld[i]) begin
        mbin[i][dat[i]] = mbin[i][dat[i]] + 1;
        msum[i] = msum[i] + int'(dat[i]);
        mcnt[i] = mcnt[i] + 1;
        if (mcnt[i] == wsz[i]) begin
          for (int b = 0; b < 4; b++) begin
            ev[i][cyc+1+b] = 1'b1;
            eb[i][cyc+1+b] = b;
            ec[i][cyc+1+b] = mbin[i][b];
            es[i][cyc+1+b] = msum[i];
            el[i][cyc+1+b] = (b == 3);
            mbin[i][b] = 0;
          end
          msum[i] = 0;
          mcnt[i] = 0;
          mwc[i]  = (mwc[i] + 1) % 65536;
        end
      end
    end
  end

  // Captured dump values for literal checks.
  int nvalid [3];
  int cap    [3][4];
  int capsum [3];
  int prv    [3][4];
  int prvsum [3];

  // Compare process: every instance, every cycle, half a clock after the edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 3; i++) begin
        chk("valid", i, int'(ov[i]), int'(ev[i][cyc]));
        chk("last", i, int'(ol[i]), ev[i][cyc] ? int'(el[i][cyc]) : 0);
        if (ev[i][cyc]) begin
          chk("bin", i, int'(ob[i]), eb[i][cyc]);
          chk("count", i, int'(oc[i]), ec[i][cyc]);
          chk("sum", i, int'(os[i]), es[i][cyc]);
          nvalid[i]++;
          if (ob[i] == 2'd0) begin
            for (int b = 0; b < 4; b++) prv[i][b] = cap[i][b];
            prvsum[i] = capsum[i];
          end
          cap[i][ob[i]] = int'(oc[i]);
          capsum[i] = int'(os[i]);
        end
        if (ez[i][cyc]) begin
          chk("rst_bin", i, int'(ob[i]), 0);
          chk("rst_count", i, int'(oc[i]), 0);
          chk("rst_sum", i, int'(os[i]), 0);
        end
        chk("wcount", i, int'(wc[i]), mwc[i]);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic feed(input int inst, input int n, input int d);
    for (int k = 0; k < n; k++) begin
      vld[inst] = 1'b1;
      dat[inst] = 2'(d);
      @(negedge clk);
    end
    vld[inst] = 1'b0;
  endtask

  task automatic rst_pulse(input int inst);
    vld[inst]   = 1'b0;
    rst_a[inst] = 1'b1;
    @(negedge clk);
    rst_a[inst] = 1'b0;
  endtask

  initial begin
    logic [5:0] s6;
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1;
      vld[i]   = 1'b0;
      dat[i]   = 2'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;

    // Exhaustive 3-bit XOR sweep into the 64-sample window.
    for (int s = 0; s < 64; s++) begin
      s6 = 6'(s);
      vld[2] = 1'b1;
      dat[2] = 2'($countones(s6[5:3] ^ s6[2:0]));
      @(negedge clk);
    end
    idle(8);
    chk("t1_bin0", 2, cap[2][0], 8);
    chk("t1_bin1", 2, cap[2][1], 24);
    chk("t1_bin2", 2, cap[2][2], 24);
    chk("t1_bin3", 2, cap[2][3], 8);
    chk("t1_sum", 2, capsum[2], 96);
    chk("t1_wc", 2, int'(wc[2]), 1);

    // Back-to-back windows of four 3s.
    feed(0, 12, 3);
    idle(8);
    chk("t2_bin0", 0, cap[0][0], 0);
    chk("t2_bin3", 0, cap[0][3], 4);
    chk("t2_sum", 0, capsum[0], 12);
    chk("t2_nvalid", 0, nvalid[0], 12);
    chk("t2_wc", 0, int'(wc[0]), 3);

    // Gapped input: valid every other cycle, samples alternate 1,2.
    for (int c = 0; c < 16; c++) begin
      vld[1] = (c % 2 == 0);
      dat[1] = ((c / 2) % 2 == 0) ? 2'd1 : 2'd2;
      @(negedge clk);
    end
    idle(8);
    chk("t3_bin0", 1, cap[1][0], 0);
    chk("t3_bin1", 1, cap[1][1], 4);
    chk("t3_bin2", 1, cap[1][2], 4);
    chk("t3_sum", 1, capsum[1], 12);
    chk("t3_wc", 1, int'(wc[1]), 1);

    // Reset during the bin-1 output cycle.
    feed(1, 8, 3);
    @(negedge clk);
    @(negedge clk);
    chk("t4_bin1_valid", 1, int'(ov[1]), 1);
    chk("t4_bin1_idx", 1, int'(ob[1]), 1);
    rst_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
    chk("t4_drop_valid", 1, int'(ov[1]), 0);
    chk("t4_drop_count", 1, int'(oc[1]), 0);
    feed(1, 8, 0);
    idle(8);
    chk("t4_bin0", 1, cap[1][0], 8);
    chk("t4_sum", 1, capsum[1], 0);
    chk("t4_wc", 1, int'(wc[1]), 1);

    // Partial window discarded by reset.
    feed(1, 5, 1);
    rst_pulse(1);
    feed(1, 8, 2);
    idle(8);
    chk("t5_bin1", 1, cap[1][1], 0);
    chk("t5_bin2", 1, cap[1][2], 8);
    chk("t5_sum", 1, capsum[1], 16);
    chk("t5_wc", 1, int'(wc[1]), 1);

    // Next window fed during a dump: shadow integrity.
    rst_pulse(0);
    feed(0, 4, 2);
    feed(0, 4, 1);
    idle(10);
    chk("t6_first_bin1", 0, prv[0][1], 0);
    chk("t6_first_bin2", 0, prv[0][2], 4);
    chk("t6_first_sum", 0, prvsum[0], 8);
    chk("t6_second_bin1", 0, cap[0][1], 4);
    chk("t6_second_bin2", 0, cap[0][2], 0);
    chk("t6_second_sum", 0, capsum[0], 4);
    chk("t6_wc", 0, int'(wc[0]), 2);

    // Randomized traffic with sparse resets on all instances.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        vld[i]   = ($urandom_range(0, 3) != 0);
        dat[i]   = 2'($urandom_range(0, 3));
        rst_a[i] = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
